// File: rtl/dsp_pkg.sv
// Shared widths, OPMODE bit positions and X/Z mux encodings for the dsp slice.
package dsp_pkg;

  localparam int AW = 18;
  localparam int BW = 18;
  localparam int DW = 18;
  localparam int MW = 36;
  localparam int PW = 48;

  localparam int OP_POST_SUB = 7;
  localparam int OP_PRE_SUB  = 6;
  localparam int OP_CIN      = 5;
  localparam int OP_PRE_EN   = 4;

  typedef enum logic [1:0] {
    X_ZERO = 2'b00,
    X_M    = 2'b01,
    X_P    = 2'b10,
    X_DAB  = 2'b11
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'b00,
    Z_PCIN = 2'b01,
    Z_P    = 2'b10,
    Z_C    = 2'b11
  } z_sel_e;

endpackage

// File: rtl/dsp_pipe_reg.sv
// Optional pipeline stage: clock-enabled register with async active-high clear,
// or a plain wire when EN is 0.
module dsp_pipe_reg #(
  parameter int W  = 18,
  parameter bit EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (EN) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (ce) q <= d;
      end
    end else begin : g_wire
      logic unused_ctrl;
      assign unused_ctrl = clk ^ rst ^ ce;
      assign q = d;
    end
  endgenerate

endmodule

// File: rtl/dsp.sv
// DSP48A1-style pre-add / multiply / post-add slice with optional pipeline stages.
// Define DSP_BCIN_CASCADE_EN to let B_INPUT="CASCADE" take the B operand from BCIN.
module dsp
  import dsp_pkg::*;
#(
  parameter int    A0REG       = 0,
  parameter int    A1REG       = 1,
  parameter int    B0REG       = 0,
  parameter int    B1REG       = 1,
  parameter int    CREG        = 1,
  parameter int    DREG        = 1,
  parameter int    MREG        = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT"
) (
  input  logic          clk,
  input  logic          RSTA,
  input  logic          RSTB,
  input  logic          RSTC,
  input  logic          RSTD,
  input  logic          RSTCARRYIN,
  input  logic          RSTM,
  input  logic          RSTOPMODE,
  input  logic          RSTP,
  input  logic          CEA,
  input  logic          CEB,
  input  logic          CEC,
  input  logic          CED,
  input  logic          CECARRYIN,
  input  logic          CEM,
  input  logic          CEOPMODE,
  input  logic          CEP,
  input  logic [AW-1:0] A,
  input  logic [BW-1:0] B,
  input  logic [DW-1:0] D,
  input  logic [PW-1:0] C,
  input  logic          CARRYIN,
  input  logic [7:0]    OPMODE,
  input  logic [BW-1:0] BCIN,
  input  logic [PW-1:0] PCIN,
  output logic [BW-1:0] BCOUT,
  output logic [MW-1:0] M,
  output logic [PW-1:0] P,
  output logic [PW-1:0] PCOUT,
  output logic          CARRYOUT,
  output logic          CARRYOUTF
);

  logic [7:0]    opm;
  logic [AW-1:0] a0, a1;
  logic [BW-1:0] b_src, b0, b1, b1_in, pre;
  logic [DW-1:0] d_r;
  logic [PW-1:0] c_r, x, z, p_r;
  logic [MW-1:0] m_in, m_r;
  logic          cin_src, cin, co_r;
  logic [PW:0]   post;

`ifdef DSP_BCIN_CASCADE_EN
  assign b_src = (B_INPUT == "CASCADE") ? BCIN : B;
`else
  logic unused_bcin;
  localparam bit unused_b_input = (B_INPUT == "CASCADE");
  assign unused_bcin = (^BCIN) ^ unused_b_input;
  assign b_src = B;
`endif

  dsp_pipe_reg #(.W(8),  .EN(OPMODEREG != 0)) u_opm (.clk(clk), .rst(RSTOPMODE), .ce(CEOPMODE), .d(OPMODE), .q(opm));
  dsp_pipe_reg #(.W(AW), .EN(A0REG != 0))     u_a0  (.clk(clk), .rst(RSTA), .ce(CEA), .d(A),  .q(a0));
  dsp_pipe_reg #(.W(AW), .EN(A1REG != 0))     u_a1  (.clk(clk), .rst(RSTA), .ce(CEA), .d(a0), .q(a1));
  dsp_pipe_reg #(.W(BW), .EN(B0REG != 0))     u_b0  (.clk(clk), .rst(RSTB), .ce(CEB), .d(b_src), .q(b0));
  dsp_pipe_reg #(.W(DW), .EN(DREG != 0))      u_d   (.clk(clk), .rst(RSTD), .ce(CED), .d(D), .q(d_r));
  dsp_pipe_reg #(.W(PW), .EN(CREG != 0))      u_c   (.clk(clk), .rst(RSTC), .ce(CEC), .d(C), .q(c_r));

  // Pre-adder sits between the two B stages and is steered by registered OPMODE.
  assign pre   = opm[OP_PRE_SUB] ? (d_r - b0) : (d_r + b0);
  assign b1_in = opm[OP_PRE_EN] ? pre : b0;

  dsp_pipe_reg #(.W(BW), .EN(B1REG != 0)) u_b1 (.clk(clk), .rst(RSTB), .ce(CEB), .d(b1_in), .q(b1));

  assign m_in = MW'(a1) * MW'(b1);

  dsp_pipe_reg #(.W(MW), .EN(MREG != 0)) u_m (.clk(clk), .rst(RSTM), .ce(CEM), .d(m_in), .q(m_r));

  always_comb begin
    x = '0;
    case (x_sel_e'(opm[1:0]))
      X_ZERO:  x = '0;
      X_M:     x = PW'(m_r);
      X_P:     x = p_r;
      X_DAB:   x = {d_r[11:0], a1, b1};
      default: x = '0;
    endcase
  end

  always_comb begin
    z = '0;
    case (z_sel_e'(opm[3:2]))
      Z_ZERO:  z = '0;
      Z_PCIN:  z = PCIN;
      Z_P:     z = p_r;
      Z_C:     z = c_r;
      default: z = '0;
    endcase
  end

  assign cin_src = (CARRYINSEL == "CARRYIN") ? CARRYIN : opm[OP_CIN];

  dsp_pipe_reg #(.W(1), .EN(CARRYINREG != 0)) u_cin (.clk(clk), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(cin_src), .q(cin));

  // Bit 48 is the carry when adding and the borrow when subtracting.
  always_comb begin
    if (opm[OP_POST_SUB]) post = {1'b0, z} - ({1'b0, x} + (PW+1)'(cin));
    else                  post = {1'b0, z} + {1'b0, x} + (PW+1)'(cin);
  end

  dsp_pipe_reg #(.W(PW), .EN(PREG != 0))       u_p  (.clk(clk), .rst(RSTP), .ce(CEP), .d(post[PW-1:0]), .q(p_r));
  dsp_pipe_reg #(.W(1),  .EN(CARRYOUTREG != 0)) u_co (.clk(clk), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(post[PW]), .q(co_r));

  assign BCOUT     = b1;
  assign M         = m_r;
  assign P         = p_r;
  assign PCOUT     = p_r;
  assign CARRYOUT  = co_r;
  assign CARRYOUTF = co_r;

endmodule

// File: tb/tb_dsp.sv
// Directed self-checking bench for the dsp slice (default build, default parameters).
module tb_dsp;

  logic        clk = 1'b0;
  logic        RSTA, RSTB, RSTC, RSTD, RSTCARRYIN, RSTM, RSTOPMODE, RSTP;
  logic        CEA, CEB, CEC, CED, CECARRYIN, CEM, CEOPMODE, CEP;
  logic [17:0] A, B, D, BCIN;
  logic [47:0] C, PCIN;
  logic        CARRYIN;
  logic [7:0]  OPMODE;
  logic [17:0] BCOUT;
  logic [35:0] M;
  logic [47:0] P, PCOUT;
  logic        CARRYOUT, CARRYOUTF;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp dut (
    .clk(clk),
    .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD),
    .RSTCARRYIN(RSTCARRYIN), .RSTM(RSTM), .RSTOPMODE(RSTOPMODE), .RSTP(RSTP),
    .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED),
    .CECARRYIN(CECARRYIN), .CEM(CEM), .CEOPMODE(CEOPMODE), .CEP(CEP),
    .A(A), .B(B), .D(D), .C(C), .CARRYIN(CARRYIN), .OPMODE(OPMODE),
    .BCIN(BCIN), .PCIN(PCIN),
    .BCOUT(BCOUT), .M(M), .P(P), .PCOUT(PCOUT),
    .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
  );

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_all_rst(input logic v);
    {RSTA, RSTB, RSTC, RSTD, RSTCARRYIN, RSTM, RSTOPMODE, RSTP} = {8{v}};
  endtask

  task automatic set_all_ce(input logic v);
    {CEA, CEB, CEC, CED, CECARRYIN, CEM, CEOPMODE, CEP} = {8{v}};
  endtask

  task automatic test_reset;
    set_all_rst(1'b1);
    set_all_ce(1'b0);
    A = 18'($urandom()); B = 18'($urandom()); D = 18'($urandom());
    BCIN = 18'($urandom()); CARRYIN = 1'($urandom());
    C = 48'({$urandom(), $urandom()}); PCIN = 48'({$urandom(), $urandom()});
    OPMODE = 8'($urandom());
    cycles(1);
    checks++; if (M !== 36'h0) begin errors++; $display("[TB] FAIL reset_m: got %h expected 0", M); end
    checks++; if (P !== 48'h0) begin errors++; $display("[TB] FAIL reset_p: got %h expected 0", P); end
    checks++; if (PCOUT !== 48'h0) begin errors++; $display("[TB] FAIL reset_pcout: got %h expected 0", PCOUT); end
    checks++; if (BCOUT !== 18'h0) begin errors++; $display("[TB] FAIL reset_bcout: got %h expected 0", BCOUT); end
    checks++; if (CARRYOUT !== 1'b0) begin errors++; $display("[TB] FAIL reset_carryout: got %b expected 0", CARRYOUT); end
    checks++; if (CARRYOUTF !== 1'b0) begin errors++; $display("[TB] FAIL reset_carryoutf: got %b expected 0", CARRYOUTF); end
  endtask

  // C - (A * (D - B)): pre-subtract, multiply, post-subtract.
  task automatic test_pre_sub_mac;
    set_all_rst(1'b0);
    set_all_ce(1'b1);
    A = 18'd20; B = 18'd10; C = 48'd350; D = 18'd25;
    PCIN = 48'd0; BCIN = 18'd0; CARRYIN = 1'b0;
    OPMODE = 8'b11011101;
    cycles(4);
    checks++; if (BCOUT !== 18'h0F) begin errors++; $display("[TB] FAIL presub_bcout: got %h expected 0f", BCOUT); end
    checks++; if (M !== 36'h12C) begin errors++; $display("[TB] FAIL presub_m: got %h expected 12c", M); end
    checks++; if (P !== 48'h32) begin errors++; $display("[TB] FAIL presub_p: got %h expected 32", P); end
    checks++; if (PCOUT !== 48'h32) begin errors++; $display("[TB] FAIL presub_pcout: got %h expected 32", PCOUT); end
    checks++; if (CARRYOUT !== 1'b0) begin errors++; $display("[TB] FAIL presub_carryout: got %b expected 0", CARRYOUT); end
    checks++; if (CARRYOUTF !== 1'b0) begin errors++; $display("[TB] FAIL presub_carryoutf: got %b expected 0", CARRYOUTF); end
  endtask

  // Pre-add only, X and Z both zero so P returns to 0.
  task automatic test_pre_add_zero;
    OPMODE = 8'b00010000;
    cycles(3);
    checks++; if (BCOUT !== 18'h23) begin errors++; $display("[TB] FAIL preadd_bcout: got %h expected 23", BCOUT); end
    checks++; if (M !== 36'h2BC) begin errors++; $display("[TB] FAIL preadd_m: got %h expected 2bc", M); end
    checks++; if (P !== 48'h0) begin errors++; $display("[TB] FAIL preadd_p: got %h expected 0", P); end
    checks++; if (PCOUT !== 48'h0) begin errors++; $display("[TB] FAIL preadd_pcout: got %h expected 0", PCOUT); end
    checks++; if (CARRYOUT !== 1'b0) begin errors++; $display("[TB] FAIL preadd_carryout: got %b expected 0", CARRYOUT); end
  endtask

  // P + P feedback with P at zero: P and carry stay put, B bypasses the pre-adder.
  task automatic test_p_feedback;
    OPMODE = 8'b00001010;
    cycles(3);
    checks++; if (BCOUT !== 18'h0A) begin errors++; $display("[TB] FAIL fb_bcout: got %h expected 0a", BCOUT); end
    checks++; if (M !== 36'hC8) begin errors++; $display("[TB] FAIL fb_m: got %h expected c8", M); end
    checks++; if (P !== 48'h0) begin errors++; $display("[TB] FAIL fb_p: got %h expected 0", P); end
    checks++; if (CARRYOUT !== 1'b0) begin errors++; $display("[TB] FAIL fb_carryout: got %b expected 0", CARRYOUT); end
  endtask

  // PCIN - ({D[11:0],A,B} + 1) borrows and wraps.
  task automatic test_concat_sub_borrow;
    A = 18'd5; B = 18'd6; D = 18'd25; PCIN = 48'd3000;
    OPMODE = 8'b10100111;
    cycles(3);
    checks++; if (BCOUT !== 18'h6) begin errors++; $display("[TB] FAIL concat_bcout: got %h expected 6", BCOUT); end
    checks++; if (M !== 36'h1E) begin errors++; $display("[TB] FAIL concat_m: got %h expected 1e", M); end
    checks++; if (P !== 48'hFE6FFFEC0BB1) begin errors++; $display("[TB] FAIL concat_p: got %h expected fe6fffec0bb1", P); end
    checks++; if (PCOUT !== 48'hFE6FFFEC0BB1) begin errors++; $display("[TB] FAIL concat_pcout: got %h expected fe6fffec0bb1", PCOUT); end
    checks++; if (CARRYOUT !== 1'b1) begin errors++; $display("[TB] FAIL concat_carryout: got %b expected 1", CARRYOUT); end
    checks++; if (CARRYOUTF !== 1'b1) begin errors++; $display("[TB] FAIL concat_carryoutf: got %b expected 1", CARRYOUTF); end
  endtask

  // Accumulate P += A*B, clear P asynchronously, then freeze it with CEP.
  task automatic test_rstp_cep;
    A = 18'd2; B = 18'd3; D = 18'd0; PCIN = 48'd0;
    OPMODE = 8'b00001001;
    cycles(3);
    RSTP = 1'b1;
    #2;
    checks++; if (P !== 48'h0) begin errors++; $display("[TB] FAIL rstp_async_p: got %h expected 0", P); end
    checks++; if (PCOUT !== 48'h0) begin errors++; $display("[TB] FAIL rstp_async_pcout: got %h expected 0", PCOUT); end
    RSTP = 1'b0;
    cycles(1);
    checks++; if (P !== 48'd6) begin errors++; $display("[TB] FAIL acc_1: got %0d expected 6", P); end
    cycles(1);
    checks++; if (P !== 48'd12) begin errors++; $display("[TB] FAIL acc_2: got %0d expected 12", P); end
    checks++; if (CARRYOUT !== 1'b0) begin errors++; $display("[TB] FAIL acc_carryout: got %b expected 0", CARRYOUT); end
    CEP = 1'b0;
    cycles(2);
    checks++; if (P !== 48'd12) begin errors++; $display("[TB] FAIL cep_hold_p: got %0d expected 12", P); end
    checks++; if (PCOUT !== 48'd12) begin errors++; $display("[TB] FAIL cep_hold_pcout: got %0d expected 12", PCOUT); end
  endtask

  initial begin
    $display("[TB] starting dsp bench");
    @(negedge clk);
    test_reset;
    test_pre_sub_mac;
    test_pre_add_zero;
    test_p_feedback;
    test_concat_sub_borrow;
    test_rstp_cep;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
